// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, receiver FSM states and the
// minimum usable baud divisor.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Divisors below this leave no room for three samples around mid-bit.
  localparam int unsigned MIN_DIV = 4;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop1,
    StStop2
  } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count. Empty reads
// return zero so the head outputs are clean while nothing is buffered.
module sync_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             empty, full, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i & ~empty;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign do_push = push_i & (~full | do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o    = empty ? '0 : mem_q[rd_ptr_q];
  assign valid_o    = ~empty;
  assign count_o    = count_q;
  assign overflow_o = push_i & ~do_push;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with runtime divisor, parity and stop-bit options, 3-sample
// majority voting and a FWFT word buffer carrying per-word error flags.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic [1:0]                    par_mode,
  input  logic                          two_stop,
  input  logic                          rx_pin,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_perr,
  output logic                          rx_ferr,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  input  logic                          clr_overrun,
  output logic                          busy
);

  localparam int unsigned BCW = $clog2(DATA_BITS);
  localparam int unsigned FW  = DATA_BITS + 2;

  rx_state_e             state_q, state_d;
  logic                  sync1_q, sync2_q, line_prev_q;
  logic [DIV_W-1:0]      div_q, cnt_q, half, div_clamped;
  logic [1:0]            par_q;
  logic                  two_stop_q;
  logic [BCW-1:0]        bit_cnt_q;
  logic [DATA_BITS-1:0]  shift_q;
  logic [1:0]            samp_q;
  logic                  perr_q, ferr_q, overrun_q;

  logic start_edge, at_s0, at_s1, at_maj, bit_end, maj, par_en, last_data, par_x;
  logic push, push_ferr, fifo_overflow;
  logic [FW-1:0] fifo_wdata, fifo_rdata;

  assign start_edge  = line_prev_q & ~sync2_q;
  assign div_clamped = (baud_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : baud_div;
  assign half        = div_q >> 1;
  assign at_s0       = (cnt_q == half - DIV_W'(1));
  assign at_s1       = (cnt_q == half);
  assign at_maj      = (cnt_q == half + DIV_W'(1));
  assign bit_end     = (cnt_q == div_q - DIV_W'(1));
  // Third sample is the live synchronised line, resolved at half+1.
  assign maj         = (samp_q[0] & samp_q[1]) | (samp_q[0] & sync2_q) | (samp_q[1] & sync2_q);
  assign par_en      = (par_q == PAR_EVEN) || (par_q == PAR_ODD);
  assign last_data   = (bit_cnt_q == BCW'(DATA_BITS - 1));
  assign par_x       = (^shift_q) ^ maj;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:   if (start_edge) state_d = StStart;
        StStart: begin
          if (at_maj && maj)  state_d = StIdle;
          else if (bit_end)   state_d = StData;
        end
        StData:   if (bit_end && last_data) state_d = par_en ? StParity : StStop1;
        StParity: if (bit_end) state_d = StStop1;
        StStop1: begin
          if (two_stop_q) begin
            if (bit_end) state_d = StStop2;
          end else if (at_maj) begin
            state_d = StIdle;
          end
        end
        StStop2:  if (at_maj) state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  // Outputs: completion push happens at the last stop bit's majority point.
  always_comb begin
    push      = 1'b0;
    push_ferr = ferr_q | ~maj;
    if (enable && at_maj &&
        (((state_q == StStop1) && !two_stop_q) || (state_q == StStop2))) begin
      push = 1'b1;
    end
    busy = (state_q != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      line_prev_q <= 1'b1;
      div_q       <= DIV_W'(MIN_DIV);
      par_q       <= PAR_NONE;
      two_stop_q  <= 1'b0;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      samp_q      <= '0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      sync1_q     <= rx_pin;
      sync2_q     <= sync1_q;
      line_prev_q <= sync2_q;
      if (state_q == StIdle) begin
        if (enable && start_edge) begin
          div_q      <= div_clamped;
          par_q      <= par_mode;
          two_stop_q <= two_stop;
          cnt_q      <= '0;
          bit_cnt_q  <= '0;
          perr_q     <= 1'b0;
          ferr_q     <= 1'b0;
        end
      end else begin
        cnt_q <= bit_end ? '0 : cnt_q + DIV_W'(1);
        if (at_s0) samp_q[0] <= sync2_q;
        if (at_s1) samp_q[1] <= sync2_q;
        if (at_maj) begin
          case (state_q)
            StData:   shift_q <= {maj, shift_q[DATA_BITS-1:1]};
            StParity: perr_q  <= (par_q == PAR_ODD) ? ~par_x : par_x;
            StStop1:  ferr_q  <= ~maj;
            default:  ;
          endcase
        end
        if (bit_end && (state_q == StData)) bit_cnt_q <= bit_cnt_q + BCW'(1);
      end
    end
  end

  assign fifo_wdata = {perr_q, push_ferr, shift_q};

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .wdata_i    (fifo_wdata),
    .pop_i      (rx_ready),
    .rdata_o    (fifo_rdata),
    .valid_o    (rx_valid),
    .count_o    (fifo_count),
    .overflow_o (fifo_overflow)
  );

  assign rx_perr = fifo_rdata[FW-1];
  assign rx_ferr = fifo_rdata[FW-2];
  assign rx_data = fifo_rdata[DATA_BITS-1:0];

  // Set wins over clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             overrun_q <= 1'b0;
    else if (fifo_overflow) overrun_q <= 1'b1;
    else if (clr_overrun)   overrun_q <= 1'b0;
  end

  assign overrun = overrun_q;

endmodule
